// File: rtl/wb_host_initiator.sv
// Wishbone classic single-master initiator: single-beat writes and incrementing
// read bursts from a valid/ready command port, per-beat results on a response port.
module wb_host_initiator #(
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned ADDR_INC = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [3:0]  cmd_sel,
   input  logic [31:0] cmd_dat,
   input  logic [7:0]  cmd_len,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_last,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned LW = 8;
   localparam int unsigned TW = 16;

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t          state, state_d;
   logic [LW-1:0]   beats_left, beats_left_d;
   logic [TW-1:0]   tmo_cnt, tmo_cnt_d;
   logic            cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_last_d;
   logic [DW-1:0]   rsp_dat_d, wbm_dat_d;
   logic            cyc_d, stb_d, we_d, busy_d;
   logic [SW-1:0]   sel_d;
   logic [AW-1:0]   adr_d;

   // State and registered-output flops
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         beats_left <= '0;
         tmo_cnt    <= '0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_last   <= 1'b0;
         rsp_dat    <= '0;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_sel_o  <= '0;
         wbm_adr_o  <= '0;
         wbm_dat_o  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         beats_left <= beats_left_d;
         tmo_cnt    <= tmo_cnt_d;
         cmd_ready  <= cmd_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_err    <= rsp_err_d;
         rsp_last   <= rsp_last_d;
         rsp_dat    <= rsp_dat_d;
         wbm_cyc_o  <= cyc_d;
         wbm_stb_o  <= stb_d;
         wbm_we_o   <= we_d;
         wbm_sel_o  <= sel_d;
         wbm_adr_o  <= adr_d;
         wbm_dat_o  <= wbm_dat_d;
         busy       <= busy_d;
      end
   end

   // Next-state and next-output logic; registers hold unless a transition updates them
   always_comb begin
      state_d      = state;
      beats_left_d = beats_left;
      tmo_cnt_d    = tmo_cnt;
      cmd_ready_d  = cmd_ready;
      rsp_valid_d  = rsp_valid;
      rsp_err_d    = rsp_err;
      rsp_last_d   = rsp_last;
      rsp_dat_d    = rsp_dat;
      cyc_d        = wbm_cyc_o;
      stb_d        = wbm_stb_o;
      we_d         = wbm_we_o;
      sel_d        = wbm_sel_o;
      adr_d        = wbm_adr_o;
      wbm_dat_d    = wbm_dat_o;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               we_d         = cmd_we;
               adr_d        = cmd_adr;
               sel_d        = cmd_sel;
               wbm_dat_d    = cmd_dat;
               beats_left_d = cmd_we ? '0 : cmd_len;
               tmo_cnt_d    = '0;
               cyc_d        = 1'b1;
               stb_d        = 1'b1;
               cmd_ready_d  = 1'b0;
               state_d      = REQ;
            end
         end
         REQ: begin
            // Ack takes priority over a timeout in the same cycle
            if (wbm_ack_i) begin
               rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_last_d  = (beats_left == '0);
               rsp_valid_d = 1'b1;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               state_d     = RSP;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b1;
               rsp_last_d  = 1'b1;
               rsp_valid_d = 1'b1;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               state_d     = RSP;
            end else begin
               tmo_cnt_d = tmo_cnt + TW'(1);
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (rsp_last) begin
                  cmd_ready_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  if (beats_left != '0) beats_left_d = beats_left - LW'(1);
                  adr_d     = wbm_adr_o + AW'(ADDR_INC);
                  tmo_cnt_d = '0;
                  cyc_d     = 1'b1;
                  stb_d     = 1'b1;
                  state_d   = REQ;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed bench for wb_host_initiator with a hand-driven Wishbone slave.
module tb_wb_host_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic [7:0]  cmd_len;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
   logic [31:0] rsp_dat;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;
   logic        ack, busy;

   int n_checks = 0;
   int n_errors = 0;

   wb_host_initiator #(.TIMEOUT(8), .ADDR_INC(4)) dut (
      .wb_clk_i (clk),       .wb_rst_i (rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr  (cmd_adr),   .cmd_sel  (cmd_sel),   .cmd_dat(cmd_dat),
      .cmd_len  (cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err  (rsp_err),   .rsp_last (rsp_last),
      .wbm_cyc_o(cyc),       .wbm_stb_o(stb),       .wbm_we_o(we),
      .wbm_sel_o(sel),       .wbm_adr_o(adr),       .wbm_dat_o(dat_o),
      .wbm_dat_i(dat_i),     .wbm_ack_i(ack),       .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Present one command at a negedge; it is accepted at the following posedge
   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [7:0] l);
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_dat = d; cmd_len = l;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("busy_high", 32'(busy), 32'd1);
   endtask

   // Slave side of one beat: hold ack low for 'waits' stb cycles, then ack
   task automatic wb_beat(input int waits, input logic [31:0] exp_adr, input logic exp_we,
                          input logic [31:0] exp_dat, input logic [31:0] rdata);
      int guard = 0;
      while (!stb && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("stb_seen", 32'(stb), 32'd1);
      for (int i = 0; i <= waits; i++) begin
         check("stb_held", 32'(stb), 32'd1);
         check("cyc_held", 32'(cyc), 32'd1);
         check("adr", adr, exp_adr);
         check("we", 32'(we), 32'(exp_we));
         check("sel", 32'(sel), 32'hF);
         if (exp_we) check("wdat", dat_o, exp_dat);
         if (i == waits) begin
            ack   = 1'b1;
            dat_i = rdata;
         end
         @(negedge clk);
      end
      ack   = 1'b0;
      dat_i = 32'h0;
      check("stb_drop", 32'(stb), 32'd0);
   endtask

   // Check the pending response and consume it
   task automatic take_rsp(input logic [31:0] exp_dat, input logic exp_err, input logic exp_last);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_dat", rsp_dat, exp_dat);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_last", 32'(rsp_last), 32'(exp_last));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_stb"}, 32'(stb), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
      cmd_dat = '0; cmd_len = '0; rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check_idle("reset");
      check("reset_cyc", 32'(cyc), 32'd0);
      check("reset_adr", adr, 32'h0);
      check("reset_rsp_last", 32'(rsp_last), 32'd0);

      // Single write, two wait states
      send_cmd(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 8'd7);
      wb_beat(2, 32'h3000_0010, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      take_rsp(32'h0, 1'b0, 1'b1);
      check_idle("wr_done");

      // Four-beat read burst with varied wait states
      begin
         int waits_tbl[4] = '{0, 1, 3, 0};
         logic [31:0] a;
         send_cmd(1'b0, 32'h3000_0400, 4'hF, 32'h0, 8'd3);
         for (int b = 0; b < 4; b++) begin
            a = 32'h3000_0400 + 32'(4 * b);
            wb_beat(waits_tbl[b], a, 1'b0, 32'h0, a ^ 32'h5A5A_5A5A);
            take_rsp(a ^ 32'h5A5A_5A5A, 1'b0, b == 3);
         end
         check_idle("burst_done");
      end

      // Slave never acks: eight stb cycles then one error response
      begin
         int n = 0;
         send_cmd(1'b0, 32'h3000_0800, 4'hF, 32'h0, 8'd2);
         while (stb && n < 20) begin
            n++;
            @(negedge clk);
         end
         check("tmo_stb_cycles", 32'(n), 32'd8);
         take_rsp(32'h0, 1'b1, 1'b1);
         for (int i = 0; i < 4; i++) check_idle("tmo_after");
      end

      // Response back-pressure holds everything stable
      send_cmd(1'b0, 32'h3000_0100, 4'hF, 32'h0, 8'd1);
      wb_beat(0, 32'h3000_0100, 1'b0, 32'h0, 32'hCAFE_0001);
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_dat", rsp_dat, 32'hCAFE_0001);
         check("bp_rsp_last", 32'(rsp_last), 32'd0);
         check("bp_no_stb", 32'(stb), 32'd0);
         @(negedge clk);
      end
      take_rsp(32'hCAFE_0001, 1'b0, 1'b0);
      wb_beat(0, 32'h3000_0104, 1'b0, 32'h0, 32'hCAFE_0002);
      take_rsp(32'hCAFE_0002, 1'b0, 1'b1);
      check_idle("bp_done");

      // Address wraps modulo 2^32
      send_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 8'd1);
      wb_beat(0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0000_00AA);
      take_rsp(32'h0000_00AA, 1'b0, 1'b0);
      wb_beat(1, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_00BB);
      take_rsp(32'h0000_00BB, 1'b0, 1'b1);
      check_idle("wrap_done");

      // Reset during REQ of the second beat
      send_cmd(1'b0, 32'h3000_0C00, 4'hF, 32'h0, 8'd3);
      wb_beat(0, 32'h3000_0C00, 1'b0, 32'h0, 32'h0000_0111);
      take_rsp(32'h0000_0111, 1'b0, 1'b0);
      check("rst_mid_stb", 32'(stb), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("rst_mid");
      check("rst_mid_cyc", 32'(cyc), 32'd0);
      check("rst_mid_adr", adr, 32'h0);
      check("rst_mid_rsp_dat", rsp_dat, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      send_cmd(1'b1, 32'h3000_0020, 4'hF, 32'h0BAD_F00D, 8'd0);
      wb_beat(1, 32'h3000_0020, 1'b1, 32'h0BAD_F00D, 32'hFFFF_FFFF);
      take_rsp(32'h0, 1'b0, 1'b1);
      check_idle("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
